latch_stage: RTL and testbench

Parametrised pipeline-stage register for the MIPS CPU core, the generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries LANES independent write channels, each with its own enable and data word, through one pipeline boundary. It applies the core's stall-vector convention and adds a flush input, a stage-valid bit and an optional saturating stall-cycle counter. One instance per stage boundary; position in the pipeline is selected by STAGE.

---
 rtl/latch_stage.sv | 154 +++++++++++++++
 tb/tb_latch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_stage.sv
// -----------------------------------------------------------------------------
// latch_stage
//
// Generic pipeline-stage register for the MIPS core. One instance sits on each
// stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries LANES independent
// write channels (enable + address + data) plus a stage-valid bit across it.
// The stage obeys the core stall vector: its own bit is stall[STAGE] and the
// downstream bit is stall[STAGE+1] (treated as not-stalled for the last stage).
//
// Optional feature, selected by the macro LATCH_STALL_COUNTER_EN:
//   defined     -> stall_cycles port and a 16-bit saturating hold counter exist
//   not defined -> no stall_cycles port and no counter logic
//
// Parameters:
//   LANES        number of write channels (default 3: GPR, HI, LO)
//   LANE_WIDTH   data bits per lane
//   ADDR_WIDTH   address bits per lane
//   STALL_WIDTH  width of the core stall vector
//   STAGE        index of this stage's bit in the stall vector (0..STALL_WIDTH-1)
//
// Ports:
//   clock         core clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   stall         core stall vector (1 = stall enabled)
//   flush         synchronous kill of the stage contents
//   in_valid      upstream stage holds a real instruction
//   in_enable     per-lane write enables, bit k = lane k
//   in_address    lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   in_data       lane k at [k*LANE_WIDTH +: LANE_WIDTH]
//   out_valid     registered in_valid
//   out_enable    registered enables
//   out_address   registered addresses
//   out_data      registered data
//   stall_cycles  saturating count of consecutive held cycles (optional)
//
// Flow control: out_valid marks that the stage holds a real instruction. There
// is no ready signal; back-pressure arrives only through the stall vector, and
// a held word keeps out_valid and its payload stable until the stage is
// released, flushed or reset.
// -----------------------------------------------------------------------------
module latch_stage #(
    parameter int LANES       = 3,
    parameter int LANE_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int STALL_WIDTH = 6,
    parameter int STAGE       = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [STALL_WIDTH-1:0]        stall,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [LANES-1:0]              in_enable,
    input  logic [LANES*ADDR_WIDTH-1:0]   in_address,
    input  logic [LANES*LANE_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    output logic [LANES-1:0]              out_enable,
    output logic [LANES*ADDR_WIDTH-1:0]   out_address,
    output logic [LANES*LANE_WIDTH-1:0]   out_data
`ifdef LATCH_STALL_COUNTER_EN
    ,
    output logic [15:0]                   stall_cycles
`endif
);

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    // Per-edge action, decoded in strict priority order.
    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_CAPTURE = 3'd3,
        ACT_HOLD    = 3'd4
    } action_t;

    logic    s_own;
    logic    s_next;
    action_t action;

    assign s_own = stall[STAGE];

    // The last stage has no downstream stall bit; it behaves as if the next
    // stage were always free, so a stall on it turns into a bubble.
    generate
        if (STAGE < STALL_WIDTH - 1) begin : g_mid_stage
            assign s_next = stall[STAGE+1];
        end else begin : g_last_stage
            assign s_next = STALL_DISABLE;
        end
    endgenerate

    // Only two bits of the stall vector matter to this stage; the rest are
    // folded here so they are visibly consumed.
    logic stall_unused;
    assign stall_unused = ^stall;

    always_comb begin
        action = ACT_CAPTURE;
        if (reset) begin
            action = ACT_RESET;
        end else if (flush) begin
            action = ACT_FLUSH;
        end else if (s_own == STALL_ENABLE && s_next == STALL_DISABLE) begin
            action = ACT_BUBBLE;
        end else if (s_own == STALL_DISABLE) begin
            action = ACT_CAPTURE;
        end else begin
            action = ACT_HOLD;
        end
    end

    // Stage register. Reset, flush and bubble all produce the same cleared
    // word; hold simply leaves the registers alone.
    always_ff @(posedge clock) begin
        case (action)
            ACT_CAPTURE: begin
                // Captured as-is: enables are not masked by in_valid.
                out_valid   <= in_valid;
                out_enable  <= in_enable;
                out_address <= in_address;
                out_data    <= in_data;
            end
            ACT_HOLD: begin
                out_valid   <= out_valid;
                out_enable  <= out_enable;
                out_address <= out_address;
                out_data    <= out_data;
            end
            default: begin
                out_valid   <= 1'b0;
                out_enable  <= '0;
                out_address <= '0;
                out_data    <= '0;
            end
        endcase
    end

`ifdef LATCH_STALL_COUNTER_EN
    // Counts consecutive held edges; pins at all-ones instead of wrapping so a
    // very long stall never reads back as a short one.
    always_ff @(posedge clock) begin
        if (action == ACT_HOLD) begin
            if (stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end else begin
            stall_cycles <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_latch_stage.sv
module tb_latch_stage;

    localparam int LANES = 3;
    localparam int LW    = 32;
    localparam int AW    = 5;
    localparam int SW    = 6;
    localparam int W     = 1 + LANES + LANES*AW + LANES*LW;

    logic                 clock;
    logic                 reset;
    logic [SW-1:0]        stall;
    logic                 flush;
    logic                 in_valid;
    logic [LANES-1:0]     in_enable;
    logic [LANES*AW-1:0]  in_address;
    logic [LANES*LW-1:0]  in_data;

    logic                 out_valid;
    logic [LANES-1:0]     out_enable;
    logic [LANES*AW-1:0]  out_address;
    logic [LANES*LW-1:0]  out_data;
    logic                 last_valid;
    logic [LANES-1:0]     last_enable;
    logic [LANES*AW-1:0]  last_address;
    logic [LANES*LW-1:0]  last_data;
`ifdef LATCH_STALL_COUNTER_EN
    logic [15:0]          stall_cycles;
    logic [15:0]          last_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
`ifdef LATCH_STALL_COUNTER_EN
    logic [15:0]  cnt_q[$];
`endif

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    latch_stage #(.LANES(LANES), .LANE_WIDTH(LW), .ADDR_WIDTH(AW),
                  .STALL_WIDTH(SW), .STAGE(4)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_enable(in_enable),
        .in_address(in_address), .in_data(in_data),
        .out_valid(out_valid), .out_enable(out_enable),
        .out_address(out_address), .out_data(out_data)
`ifdef LATCH_STALL_COUNTER_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    latch_stage #(.LANES(LANES), .LANE_WIDTH(LW), .ADDR_WIDTH(AW),
                  .STALL_WIDTH(SW), .STAGE(5)) dut_last (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_enable(in_enable),
        .in_address(in_address), .in_data(in_data),
        .out_valid(last_valid), .out_enable(last_enable),
        .out_address(last_address), .out_data(last_data)
`ifdef LATCH_STALL_COUNTER_EN
        , .stall_cycles(last_stall_cycles)
`endif
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic                rst;
        logic                fl;
        logic [SW-1:0]       st;
        logic                v;
        logic [LANES-1:0]    en;
        logic [LANES*AW-1:0] a;
        logic [LANES*LW-1:0] d;
        logic                ev;
        logic [LANES-1:0]    een;
        logic [LANES*AW-1:0] ea;
        logic [LANES*LW-1:0] ed;
        logic [15:0]         ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic fl, input logic [SW-1:0] st,
        input logic v, input logic [2:0] en,
        input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
        input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
        input logic ev, input logic [2:0] een,
        input logic [4:0] ea2, input logic [4:0] ea1, input logic [4:0] ea0,
        input logic [31:0] ed2, input logic [31:0] ed1, input logic [31:0] ed0,
        input logic [15:0] ecnt);
        vec_t r;
        r.rst = rst; r.fl = fl; r.st = st; r.v = v; r.en = en;
        r.a = {a2, a1, a0}; r.d = {d2, d1, d0};
        r.ev = ev; r.een = een; r.ea = {ea2, ea1, ea0}; r.ed = {ed2, ed1, ed0};
        r.ecnt = ecnt;
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check_bundle(input string name, input logic [W-1:0] got,
                                input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got v=%0b en=%b addr=%h data=%h, expected v=%0b en=%b addr=%h data=%h",
                     name, got[W-1], got[W-2 -: LANES], got[LANES*LW +: LANES*AW],
                     got[LANES*LW-1:0], exp[W-1], exp[W-2 -: LANES],
                     exp[LANES*LW +: LANES*AW], exp[LANES*LW-1:0]);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got,
                           input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input string name, input vec_t v);
        logic [W-1:0] exp;
        reset      = v.rst;
        flush      = v.fl;
        stall      = v.st;
        in_valid   = v.v;
        in_enable  = v.en;
        in_address = v.a;
        in_data    = v.d;
        exp_q.push_back({v.ev, v.een, v.ea, v.ed});
`ifdef LATCH_STALL_COUNTER_EN
        cnt_q.push_back(v.ecnt);
`endif
        @(posedge clock);
        #1;
        exp = exp_q.pop_front();
        check_bundle(name, {out_valid, out_enable, out_address, out_data}, exp);
`ifdef LATCH_STALL_COUNTER_EN
        check16({name, " stall_cycles"}, stall_cycles, cnt_q.pop_front());
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0;
        in_enable = '0; in_address = '0; in_data = '0;

        // reset twice with busy inputs
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1, 0, 6'b000000, 1, 3'b111, 5'h1f, 5'h1f, 5'h1f,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd0));
        // pass-through
        vecs.push_back(mk(0, 0, 6'b000000, 1, 3'b101, 5'd3, 5'd7, 5'd8,
            32'hCAFEF00D, 32'h0BADF00D, 32'h12345678,
            1, 3'b101, 5'd3, 5'd7, 5'd8, 32'hCAFEF00D, 32'h0BADF00D, 32'h12345678, 16'd0));
        // bubble: own stall, next free
        vecs.push_back(mk(0, 0, 6'b010000, 1, 3'b111, 5'h1f, 5'h1f, 5'h1f,
            32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
            0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd0));
        // capture 0x42 then hold for 5 cycles
        vecs.push_back(mk(0, 0, 6'b000000, 1, 3'b011, 5'd0, 5'd4, 5'd2,
            32'h22222222, 32'h11111111, 32'h00000042,
            1, 3'b011, 5'd0, 5'd4, 5'd2, 32'h22222222, 32'h11111111, 32'h00000042, 16'd0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 0, 6'b110000, 0, 3'b100, 5'd9, 5'd9, 5'd9,
                32'h99999999, 32'h99999999, 32'h99999999,
                1, 3'b011, 5'd0, 5'd4, 5'd2, 32'h22222222, 32'h11111111, 32'h00000042,
                16'(i)));
        // release captures new word, in_valid=0 captured as-is
        vecs.push_back(mk(0, 0, 6'b000000, 0, 3'b100, 5'd1, 5'd0, 5'd0,
            32'h0, 32'h0, 32'h00000077,
            0, 3'b100, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h00000077, 16'd0));
        // capture, hold, then flush during hold
        vecs.push_back(mk(0, 0, 6'b000000, 1, 3'b111, 5'd5, 5'd6, 5'd7,
            32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001,
            1, 3'b111, 5'd5, 5'd6, 5'd7, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 16'd0));
        vecs.push_back(mk(0, 0, 6'b110000, 0, 3'b000, 0, 0, 0, 0, 0, 0,
            1, 3'b111, 5'd5, 5'd6, 5'd7, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 16'd1));
        vecs.push_back(mk(0, 1, 6'b110000, 1, 3'b111, 5'h1f, 5'h1f, 5'h1f,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd0));
        // bits below STAGE are ignored
        vecs.push_back(mk(0, 0, 6'b001111, 1, 3'b010, 5'd0, 5'h10, 5'd0,
            32'h0, 32'h13579BDF, 32'h0,
            1, 3'b010, 5'd0, 5'h10, 5'd0, 32'h0, 32'h13579BDF, 32'h0, 16'd0));
        // hold then reset mid-hold, then normal capture
        vecs.push_back(mk(0, 0, 6'b110000, 0, 3'b101, 5'd2, 5'd2, 5'd2,
            32'h55555555, 32'h55555555, 32'h55555555,
            1, 3'b010, 5'd0, 5'h10, 5'd0, 32'h0, 32'h13579BDF, 32'h0, 16'd1));
        vecs.push_back(mk(1, 0, 6'b110000, 0, 3'b101, 5'd2, 5'd2, 5'd2,
            32'h55555555, 32'h55555555, 32'h55555555,
            0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 6'b000000, 1, 3'b001, 5'd0, 5'd0, 5'h1e,
            32'h0, 32'h0, 32'hFEEDFACE,
            1, 3'b001, 5'd0, 5'd0, 5'h1e, 32'h0, 32'h0, 32'hFEEDFACE, 16'd0));
        // flush without stall
        vecs.push_back(mk(0, 1, 6'b000000, 1, 3'b111, 5'd3, 5'd3, 5'd3,
            32'h12121212, 32'h12121212, 32'h12121212,
            0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd0));
        // only the downstream bit set: this stage still captures
        vecs.push_back(mk(0, 0, 6'b100000, 1, 3'b110, 5'd4, 5'd3, 5'd0,
            32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0,
            1, 3'b110, 5'd4, 5'd3, 5'd0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 16'd0));

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // ---- last stage: stall[5] alone means bubble there ----
        apply("last_a", mk(0, 0, 6'b000000, 1, 3'b111, 5'd1, 5'd2, 5'd3,
            32'h01010101, 32'h02020202, 32'h03030303,
            1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h01010101, 32'h02020202, 32'h03030303, 16'd0));
        check_bundle("last_capture", {last_valid, last_enable, last_address, last_data},
            {1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h01010101, 32'h02020202, 32'h03030303});
        apply("last_b", mk(0, 0, 6'b100000, 1, 3'b111, 5'h1f, 5'h1f, 5'h1f,
            32'h77777777, 32'h77777777, 32'h77777777,
            1, 3'b111, 5'h1f, 5'h1f, 5'h1f, 32'h77777777, 32'h77777777, 32'h77777777, 16'd0));
        check_bundle("last_bubble", {last_valid, last_enable, last_address, last_data}, '0);
        apply("last_c", mk(0, 0, 6'b000000, 1, 3'b111, 5'd1, 5'd2, 5'd3,
            32'h01010101, 32'h02020202, 32'h03030303,
            1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h01010101, 32'h02020202, 32'h03030303, 16'd0));
        apply("last_d", mk(0, 0, 6'b110000, 0, 3'b000, 0, 0, 0, 0, 0, 0,
            1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h01010101, 32'h02020202, 32'h03030303, 16'd1));
        check_bundle("last_bubble_stall4", {last_valid, last_enable, last_address, last_data}, '0);

`ifdef LATCH_STALL_COUNTER_EN
        // ---- saturation: keep holding far past 16 bits ----
        repeat (65540) @(posedge clock);
        #1;
        check16("saturate", stall_cycles, 16'hFFFF);
        check_bundle("saturate_hold", {out_valid, out_enable, out_address, out_data},
            {1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h01010101, 32'h02020202, 32'h03030303});
        apply("sat_release", mk(0, 0, 6'b000000, 1, 3'b001, 5'd0, 5'd0, 5'd9,
            32'h0, 32'h0, 32'h0000BEEF,
            1, 3'b001, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0000BEEF, 16'd0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
